// File: rtl/heap_free_engine_pkg.sv
// ----------------------------------------------------------------------------
// heap_free_engine_pkg
// Shared memory-management definitions for the heap free path.
//   - Default heap geometry: base address, block size (log2) and block count
//   - Length-table entry width (lengths are counted in blocks)
//   - FSM state encoding of the free engine
// No ports; imported by the interface and the engine.
// ----------------------------------------------------------------------------
package heap_free_engine_pkg;

    localparam logic [31:0] HEAP_BASE_DEF   = 32'h0010_0000;
    localparam int          BLOCK_SHIFT_DEF = 5;
    localparam int          NUM_BLOCKS_DEF  = 64;
    localparam int          IDX_W_DEF       = $clog2(NUM_BLOCKS_DEF);
    localparam int          LEN_W           = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACK    = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_DONE   = 3'd4,
        ST_SETTLE = 3'd5
    } hfe_state_e;

endpackage

// File: rtl/heap_free_engine_if.sv
// ----------------------------------------------------------------------------
// heap_free_engine_if
// Bundles every non-clock signal of the free engine.
//   free_request_i / free_address_i : request from the free circular buffer
//   idle / analysis                 : engine ready / request-consumed pulse
//   len_addr_o / len_data_i / len_we_o : length-table port (1-cycle read)
//   bm_clr_o / bm_clr_idx_o         : allocation-bitmap clear strobe + index
//   free_done_o / free_error_o      : completion / rejection pulses
//   state_o                         : engine FSM state, for observation
// Handshake: free_request_i is a level; the engine consumes it only while
// idle is high, and acknowledges exactly once with a one-cycle analysis
// pulse. The requester advances to its next entry on analysis.
// modport slave is the engine, modport master the surrounding logic.
// ----------------------------------------------------------------------------
interface heap_free_engine_if
    import heap_free_engine_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);
    logic              free_request_i;
    logic [31:0]       free_address_i;
    logic              idle;
    logic              analysis;
    logic [IDX_W-1:0]  len_addr_o;
    logic [LEN_W-1:0]  len_data_i;
    logic              len_we_o;
    logic              bm_clr_o;
    logic [IDX_W-1:0]  bm_clr_idx_o;
    logic              free_done_o;
    logic              free_error_o;
    hfe_state_e        state_o;

    modport slave (
        input  free_request_i, free_address_i, len_data_i,
        output idle, analysis, len_addr_o, len_we_o, bm_clr_o,
               bm_clr_idx_o, free_done_o, free_error_o, state_o
    );

    modport master (
        output free_request_i, free_address_i, len_data_i,
        input  idle, analysis, len_addr_o, len_we_o, bm_clr_o,
               bm_clr_idx_o, free_done_o, free_error_o, state_o
    );

endinterface

// File: rtl/heap_free_engine.sv
// ----------------------------------------------------------------------------
// heap_free_engine
// Frees one heap allocation per request: validates the byte address, reads
// the allocation length from the length table, clears that many bitmap bits
// in ascending block order, then clears the length-table entry.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : heap_free_engine_if.slave (request, length table, bitmap, status)
// All outputs are decoded from the registered state or from registers.
// ----------------------------------------------------------------------------
module heap_free_engine
    import heap_free_engine_pkg::*;
#(
    parameter logic [31:0] HEAP_BASE   = HEAP_BASE_DEF,
    parameter int          BLOCK_SHIFT = BLOCK_SHIFT_DEF,
    parameter int          NUM_BLOCKS  = NUM_BLOCKS_DEF
)(
    input  logic               clk,
    input  logic               rst,
    heap_free_engine_if.slave  bus
);

    localparam int          IDX_W      = $clog2(NUM_BLOCKS);
    localparam int          SUM_W      = ((IDX_W > LEN_W) ? IDX_W : LEN_W) + 1;
    localparam logic [31:0] HEAP_BYTES = 32'(NUM_BLOCKS) << BLOCK_SHIFT;

    hfe_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              settle_q, settle_d;

    logic [31:0]       offset;
    logic              addr_bad;
    logic [SUM_W-1:0]  span;
    logic              len_bad;

    // Unsigned wrap makes addresses below the heap base land far above
    // HEAP_BYTES, so a single range compare rejects both directions.
    assign offset   = bus.free_address_i - HEAP_BASE;
    assign addr_bad = (offset >= HEAP_BYTES) || (offset[BLOCK_SHIFT-1:0] != '0);

    assign span     = SUM_W'(idx_q) + SUM_W'(bus.len_data_i);
    assign len_bad  = (bus.len_data_i == '0) || (span > SUM_W'(NUM_BLOCKS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            idx_q    <= '0;
            cur_q    <= '0;
            rem_q    <= '0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        idx_d    = idx_q;
        cur_d    = cur_q;
        rem_d    = rem_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.free_request_i) begin
                    err_d   = addr_bad;
                    // The table index is registered on capture so the
                    // address is stable throughout ACK; the one-cycle read
                    // then returns data during LOOKUP.
                    if (!addr_bad) begin
                        idx_d = offset[BLOCK_SHIFT +: IDX_W];
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = err_q ? ST_DONE : ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (len_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cur_d   = idx_q;
                    rem_d   = bus.len_data_i;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cur_d = cur_q + IDX_W'(1);
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                settle_d = 1'b0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Two dead cycles let the buffer's registered request and
                // read-pointer/SRAM latency catch up before re-arming.
                if (settle_q) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.idle         = (state_q == ST_IDLE);
    assign bus.analysis     = (state_q == ST_ACK);
    assign bus.len_addr_o   = idx_q;
    assign bus.len_we_o     = (state_q == ST_DONE) && !err_q;
    assign bus.bm_clr_o     = (state_q == ST_CLEAR);
    assign bus.bm_clr_idx_o = cur_q;
    assign bus.free_done_o  = (state_q == ST_DONE) && !err_q;
    assign bus.free_error_o = (state_q == ST_DONE) && err_q;
    assign bus.state_o      = state_q;

endmodule

// File: doc/heap_free_engine.md
HEAP_FREE_ENGINE -- requirements
Module: heap_free_engine

Interface
REQ-001 Parameter HEAP_BASE, 32'h0010_0000, byte address of heap block 0.
REQ-002 Parameter BLOCK_SHIFT, 5, log2 of block size in bytes (32 B blocks).
REQ-003 Parameter NUM_BLOCKS, 64, number of heap blocks; index width IDX_W = 6.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 free_request_i  input  1  free request from free circular buffer, level, qualified only in IDLE.
REQ-007 free_address_i  input  32  byte address to free, valid with free_request_i.
REQ-008 idle  output  1  engine ready to accept a request; high only in IDLE.
REQ-009 analysis  output  1  one-cycle pulse: request consumed; advances the buffer read pointer.
REQ-010 len_addr_o  output  IDX_W  length-table address (block index of freed head).
REQ-011 len_data_i  input  7  length-table read data, in blocks, one-cycle synchronous read latency.
REQ-012 len_we_o  output  1  one-cycle write strobe clearing length-table entry at len_addr_o to zero.
REQ-013 bm_clr_o  output  1  allocation-bitmap clear strobe, one block per cycle.
REQ-014 bm_clr_idx_o  output  IDX_W  block index cleared when bm_clr_o high.
REQ-015 free_done_o  output  1  one-cycle pulse: free completed successfully.
REQ-016 free_error_o  output  1  one-cycle pulse: request rejected, no bitmap/table change.

Function
REQ-017 FSM states IDLE, ACK, LOOKUP, CLEAR, DONE, SETTLE; every output decoded from registered state or a register.
REQ-018 IDLE: on free_request_i, latch address, compute offset = free_address_i - HEAP_BASE (32-bit unsigned, wrap), go ACK; no request -> stay.
REQ-019 Address invalid when offset >= NUM_BLOCKS << BLOCK_SHIFT or offset[BLOCK_SHIFT-1:0] != 0; addresses below HEAP_BASE fail via wrap.
REQ-020 ACK: analysis high exactly this cycle; invalid -> DONE with error; valid -> len_addr_o = offset >> BLOCK_SHIFT, go LOOKUP.
REQ-021 LOOKUP: sample len_data_i at end of cycle; len 0 or index+len > NUM_BLOCKS -> DONE with error; else load cur = index, rem = len, go CLEAR.
REQ-022 CLEAR: each cycle bm_clr_o = 1, bm_clr_idx_o = cur, cur+1, rem-1; leave for DONE after rem==1 cycle; exactly len strobes, ascending.
REQ-023 DONE: success -> free_done_o and len_we_o high one cycle; error -> free_error_o only; go SETTLE.
REQ-024 SETTLE: two cycles, idle low, free_request_i ignored (covers buffer's registered request and pointer/SRAM latency), then IDLE.
REQ-025 Successful latency: request sampled cycle T -> analysis T+1, first clear T+3, free_done_o T+3+len, idle high T+6+len.
REQ-026 Address-error latency: analysis T+1, free_error_o T+2, idle high T+5; length-error: free_error_o T+3, idle high T+6.
REQ-027 free_request_i outside IDLE never captured and never produces analysis.
REQ-028 free_done_o and free_error_o never both high; exactly one of them per analysis pulse.

Reset
REQ-029 rst asserted at any time -> state IDLE immediately; in-progress clear abandoned without further strobes.
REQ-030 Reset values: idle 1 (registered from IDLE), analysis 0, len_we_o 0, bm_clr_o 0, free_done_o 0, free_error_o 0, len_addr_o 0, bm_clr_idx_o 0.

Structure
REQ-031 Shared memory-management package holds FSM state encoding, BLOCK_SHIFT/NUM_BLOCKS/HEAP_BASE defaults, length width 7.
REQ-032 Single flat module; no sub-module; range/alignment check inline combinational.

Verification
REQ-033 free 0x0010_0040, len table[2]=3 -> analysis T+1, clears idx 2,3,4 at T+3..T+5, len_we_o with addr 2 and free_done_o at T+6.
REQ-034 free 0x0010_0044 (misaligned) and 0x000F_FFE0 (below base) -> analysis once each, free_error_o, zero bm_clr_o, zero len_we_o.
REQ-035 free 0x0010_07E0, table[63]=2 -> free_error_o (63+2 > 64); table[63]=1 -> single clear idx 63, free_done_o.
REQ-036 free_request_i held high continuously with two queued addresses -> exactly one analysis per request, none during ACK..SETTLE.
REQ-037 table entry 0 -> free_error_o at T+3, no clears; rst pulsed mid-CLEAR of len 10 -> strobes stop at once, idle 1, next request served normally.
